// File: rtl/fcmp_pipe.sv
// rtl/fcmp_pipe.sv - two-stage FPU compare/select unit (FEQ/FLT/FLE/FMIN/FMAX)
// S1 captures the operands and their magnitude compares; S2 forms and holds the result.
module fcmp_pipe #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [31:0]      in_x1,
  input  logic [31:0]      in_x2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       inflight
);

  localparam logic [2:0] OP_FEQ  = 3'b000;
  localparam logic [2:0] OP_FLT  = 3'b001;
  localparam logic [2:0] OP_FLE  = 3'b010;
  localparam logic [2:0] OP_FMIN = 3'b011;
  localparam logic [2:0] OP_FMAX = 3'b100;

  logic             s1_valid;
  logic [2:0]       s1_op;
  logic [31:0]      s1_x1;
  logic [31:0]      s1_x2;
  logic [TAG_W-1:0] s1_tag;
  logic             s1_mlt;
  logic             s1_meq;
  logic             s1_bz;

  logic             s2_valid;

  logic             s1_adv;
  logic             in_fire;
  logic             out_fire;

  logic             fle;
  logic             feq;
  logic             flt;
  logic [31:0]      res;

  assign s1_adv    = s1_valid & (~s2_valid | out_ready);
  assign in_ready  = ~s1_valid | s1_adv;
  assign in_fire   = in_valid & in_ready;
  assign out_valid = s2_valid;
  assign out_fire  = s2_valid & out_ready;

  // Magnitude compares are done up front so S2 only needs sign-based muxing.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_x1    <= '0;
      s1_x2    <= '0;
      s1_tag   <= '0;
      s1_mlt   <= 1'b0;
      s1_meq   <= 1'b0;
      s1_bz    <= 1'b0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_op    <= in_op;
      s1_x1    <= in_x1;
      s1_x2    <= in_x2;
      s1_tag   <= in_tag;
      s1_mlt   <= in_x1[30:0] < in_x2[30:0];
      s1_meq   <= in_x1[30:0] == in_x2[30:0];
      s1_bz    <= (in_x1[30:0] == 31'd0) & (in_x2[30:0] == 31'd0);
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_comb begin
    fle = 1'b0;
    case ({s1_x1[31], s1_x2[31]})
      2'b00:   fle = s1_mlt | s1_meq;
      2'b01:   fle = s1_bz;
      2'b10:   fle = 1'b1;
      2'b11:   fle = ~s1_mlt;
      default: fle = 1'b0;
    endcase
    feq = ((s1_x1[31] == s1_x2[31]) & s1_meq) | s1_bz;
    flt = fle & ~feq;
    res = '0;
    case (s1_op)
      OP_FEQ:  res = {31'd0, feq};
      OP_FLT:  res = {31'd0, flt};
      OP_FLE:  res = {31'd0, fle};
      OP_FMIN: res = fle ? s1_x1 : s1_x2;
      OP_FMAX: res = fle ? s1_x2 : s1_x1;
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      out_y    <= '0;
      out_tag  <= '0;
    end else if (s1_adv) begin
      s2_valid <= 1'b1;
      out_y    <= res;
      out_tag  <= s1_tag;
    end else if (out_fire) begin
      s2_valid <= 1'b0;
    end
  end

  // Bounded by the two stages, so +1/-1 can never wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 2'd0;
    end else begin
      case ({in_fire, out_fire})
        2'b10:   inflight <= inflight + 2'd1;
        2'b01:   inflight <= inflight - 2'd1;
        default: inflight <= inflight;
      endcase
    end
  end

endmodule
